// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream.
// Two line buffers plus a two-column history feed one output register that holds each window.
module window_gen_3x3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_sof,
  input  logic [PIX_W-1:0]             in_pixel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [2:0][2:0][PIX_W-1:0]   out_window,
  output logic [9:0]                   out_x,
  output logic [9:0]                   out_y,
  output logic                         out_last
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // The source must hold valid and its data until that edge. in_ready depends only on
  // out_valid and out_ready, never on in_valid.

  localparam int         AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  logic [9:0]       x_cnt, y_cnt;
  logic [9:0]       cur_x, cur_y;
  logic [AW-1:0]    wr_idx;
  logic             in_fire;
  logic             win_load;
  logic             win_last;

  logic [PIX_W-1:0] line0_mem [IMG_W];
  logic [PIX_W-1:0] line1_mem [IMG_W];
  logic [PIX_W-1:0] line0_rd, line1_rd;

  // Column slices are indexed by row: [0] = two lines up, [1] = one line up, [2] = current.
  logic [2:0][PIX_W-1:0]       new_col;
  logic [1:0][2:0][PIX_W-1:0]  hist_q;
  logic [2:0][2:0][PIX_W-1:0]  win_next;

  assign in_ready = !out_valid || out_ready;
  assign in_fire  = in_valid && in_ready;

  // An accepted start-of-frame pixel overrides whatever the counters hold.
  assign cur_x  = in_sof ? 10'd0 : x_cnt;
  assign cur_y  = in_sof ? 10'd0 : y_cnt;
  assign wr_idx = cur_x[AW-1:0];

  assign line0_rd = line0_mem[wr_idx];
  assign line1_rd = line1_mem[wr_idx];

  assign new_col  = {in_pixel, line1_rd, line0_rd};
  assign win_load = (cur_x >= 10'd2) && (cur_y >= 10'd2);
  assign win_last = (cur_x == X_LAST) && (cur_y == Y_LAST);

  always_comb begin
    win_next = '0;
    for (int r = 0; r < 3; r++) begin
      win_next[r][0] = hist_q[0][r];
      win_next[r][1] = hist_q[1][r];
      win_next[r][2] = new_col[r];
    end
  end

  // Line buffers are deliberately left out of reset; rows 0 and 1 of every frame refill them.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      line1_mem[wr_idx] <= in_pixel;
      line0_mem[wr_idx] <= line1_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_fire) begin
      if (cur_x == X_LAST) begin
        x_cnt <= '0;
        y_cnt <= (cur_y == Y_LAST) ? 10'd0 : cur_y + 10'd1;
      end else begin
        x_cnt <= cur_x + 10'd1;
        y_cnt <= cur_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else if (in_fire) begin
      hist_q[0] <= hist_q[1];
      hist_q[1] <= new_col;
    end
  end

  // in_fire implies the register is empty or draining, so a load never drops a held window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_window <= '0;
      out_x      <= '0;
      out_y      <= '0;
      out_last   <= 1'b0;
    end else if (in_fire && win_load) begin
      out_valid  <= 1'b1;
      out_window <= win_next;
      out_x      <= cur_x - 10'd1;
      out_y      <= cur_y - 10'd1;
      out_last   <= win_last;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_window_gen_3x3.sv
// Bench for window_gen_3x3: random handshakes against a frame-image reference model
// that cuts each expected window straight out of a stored 2-D picture.
module tb_window_gen_3x3;

  localparam int W_ = 8;
  localparam int H_ = 6;
  localparam int P  = 4;
  localparam int EW = 9 * P + 21;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic                     in_sof = 1'b0;
  logic [P-1:0]             in_pixel = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b0;
  logic [2:0][2:0][P-1:0]   out_window;
  logic [9:0]               out_x, out_y;
  logic                     out_last;

  window_gen_3x3 #(.IMG_W(W_), .IMG_H(H_), .PIX_W(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_window(out_window),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int              n_checks = 0;
  int              n_pass   = 0;
  logic [EW-1:0]   exp_q[$];
  logic [P:0]      src_q[$];
  logic [P-1:0]    img [H_][W_];
  bit              exp_valid = 1'b0;
  int              mx = 0, my = 0;
  int              obs_win = 0, obs_last = 0;
  logic [19:0]     last_xy;
  logic [EW-1:0]   first_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [EW-1:0] obs_word();
    return {out_window, out_x, out_y, out_last};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_frame(input bit rnd, input bit with_sof);
    for (int y = 0; y < H_; y++)
      for (int x = 0; x < W_; x++) begin
        logic [P-1:0] px;
        px = rnd ? P'($urandom) : P'((x + y) % 16);
        src_q.push_back({with_sof && x == 0 && y == 0, px});
      end
  endtask

  task automatic step(input bit v_en, input bit r_en);
    bit                      pushed;
    logic [P:0]              sp;
    logic [2:0][2:0][P-1:0]  ew;
    @(negedge clk);
    if (v_en && src_q.size() > 0) begin
      in_valid = 1'b1;
      {in_sof, in_pixel} = src_q[0];
    end else begin
      in_valid = 1'b0;
      in_sof   = 1'($urandom_range(0, 1));
      in_pixel = P'($urandom);
    end
    out_ready = r_en;
    #1;
    check("out_valid", out_valid, exp_valid);
    check("in_ready", in_ready, !exp_valid || r_en);
    if (exp_valid && exp_q.size() > 0) check("window", obs_word(), exp_q[0]);
    if (out_valid && out_ready) begin
      obs_win++;
      if (obs_win == 1) first_word = obs_word();
      if (out_last) begin
        obs_last++;
        last_xy = {out_x, out_y};
      end
    end
    if (exp_valid && r_en && exp_q.size() > 0) void'(exp_q.pop_front());
    pushed = 1'b0;
    if (in_valid && (!exp_valid || r_en)) begin
      sp = src_q.pop_front();
      if (sp[P]) begin
        mx = 0;
        my = 0;
      end
      img[my][mx] = sp[P-1:0];
      if (mx >= 2 && my >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ew[r][c] = img[my-2+r][mx-2+c];
        exp_q.push_back({ew, 10'(mx - 1), 10'(my - 1), (mx == W_-1) && (my == H_-1)});
        pushed = 1'b1;
      end
      if (mx == W_-1) begin
        mx = 0;
        my = (my == H_-1) ? 0 : my + 1;
      end else mx++;
    end
    exp_valid = pushed || (exp_valid && !r_en);
  endtask

  task automatic run_all(input int vp, input int rp, input int stall_n);
    int  cyc;
    int  stall_left;
    bit  stalled;
    bit  v, r;
    cyc = 0;
    stall_left = stall_n;
    stalled = 1'b0;
    while ((src_q.size() > 0 || exp_valid) && cyc < 5000) begin
      v = ($urandom_range(1, 100) <= vp);
      r = ($urandom_range(1, 100) <= rp);
      if (exp_valid && !stalled && stall_left > 0) begin
        r = 1'b0;
        stall_left--;
        if (stall_left == 0) stalled = 1'b1;
      end
      step(v, r);
      cyc++;
    end
    check("drain_timeout", 64'(src_q.size()) + 64'(exp_valid), 0);
  endtask

  task automatic clear_obs();
    obs_win = 0;
    obs_last = 0;
    last_xy = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0][2:0][P-1:0] fw;
    int guard;

    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_window", out_window, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // Ramp frame, no gaps.
    clear_obs();
    load_frame(1'b0, 1'b1);
    run_all(100, 100, 0);
    fw = first_word[EW-1:21];
    check("first_x", first_word[20:11], 1);
    check("first_y", first_word[10:1], 1);
    check("first_w11", fw[1][1], 2);
    check("first_w00", fw[0][0], 0);
    check("first_w22", fw[2][2], 4);
    check("ramp_windows", obs_win, 24);
    check("ramp_lasts", obs_last, 1);
    check("ramp_last_xy", last_xy, {10'd6, 10'd4});

    // Same frame with a 5-cycle stall on the first window.
    clear_obs();
    load_frame(1'b0, 1'b1);
    run_all(100, 100, 5);
    check("stall_windows", obs_win, 24);
    check("stall_lasts", obs_last, 1);

    // Three back-to-back random frames with random gaps on both sides.
    clear_obs();
    repeat (3) load_frame(1'b1, 1'b1);
    run_all(50, 50, 0);
    check("rand_windows", obs_win, 72);
    check("rand_lasts", obs_last, 3);

    // Frame cut short by a new start-of-frame at (5,3).
    clear_obs();
    for (int i = 0; i < 3 * W_ + 5; i++) src_q.push_back({i == 0, P'($urandom)});
    load_frame(1'b1, 1'b1);
    run_all(100, 100, 0);
    check("sof_windows", obs_win, 33);
    check("sof_lasts", obs_last, 1);

    // Reset mid-frame while a window is held, then a frame without sof.
    clear_obs();
    load_frame(1'b1, 1'b1);
    guard = 0;
    while (!(exp_valid && src_q.size() < W_ * H_ - 20) && guard < 200) begin
      step(1'b1, 1'b1);
      guard++;
    end
    check("pre_reset_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_window", out_window, 0);
    check("mid_rst_out_xy", {out_x, out_y}, 0);
    check("mid_rst_out_last", out_last, 0);
    rst_n = 1'b1;
    exp_q.delete();
    src_q.delete();
    exp_valid = 1'b0;
    mx = 0;
    my = 0;
    clear_obs();
    load_frame(1'b1, 1'b0);
    run_all(100, 100, 0);
    check("post_rst_windows", obs_win, 24);
    check("post_rst_lasts", obs_last, 1);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
WINDOW_GEN_3X3 -- requirements
Module: window_gen_3x3

Interface
REQ-001 Parameter IMG_W, default 64: pixels per line, range 3..1024.
REQ-002 Parameter IMG_H, default 64: lines per frame, range 3..1024.
REQ-003 Parameter PIX_W, default 4: pixel width in bits.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  in_pixel is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_pixel this cycle.
REQ-008 in_sof  input  1  start of frame; qualifies the accepted pixel as (x=0,y=0).
REQ-009 in_pixel  input  PIX_W  raster-order pixel, left-to-right, top-to-bottom.
REQ-010 out_valid  output  1  out_window/out_x/out_y/out_last are valid.
REQ-011 out_ready  input  1  downstream kernel accepts the window.
REQ-012 out_window  output  PIX_W x [2:0][2:0]  3x3 window indexed [row][col]; row 0 is top line, col 0 is leftmost.
REQ-013 out_x, out_y  output  10 each  coordinates of window centre pixel.
REQ-014 out_last  output  1  final window of the frame.

Function
REQ-015 An input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready.
REQ-016 in_ready = !out_valid || out_ready (single output register, no combinational path from in_valid to in_ready).
REQ-017 Column counter x and row counter y track the position of the next accepted pixel; x wraps IMG_W-1 -> 0 and increments y; y wraps IMG_H-1 -> 0 at the final pixel.
REQ-018 An accepted pixel with in_sof=1 is treated as (0,0) regardless of counter state; counters become (1,0) after it.
REQ-019 Two line buffers of depth IMG_W x PIX_W hold the previous two lines; accepted pixel at column x is written to line 1 and the old line 1 entry at x moves to line 0 in the same cycle.
REQ-020 A 3-column shift register holds {line0, line1, current} pixels for the last three accepted columns; it shifts only on input transfers.
REQ-021 Accepting pixel (x,y) with x>=2 and y>=2 loads the output register on that edge: out_valid=1, centre (x-1,y-1), out_window[r][c] = pixel(x-2+c, y-2+r).
REQ-022 Latency: one cycle from accepting pixel (x,y) to out_valid with its window; no windows produced for border centres, giving exactly (IMG_W-2)*(IMG_H-2) windows per frame.
REQ-023 out_last=1 only on the window centred at (IMG_W-2, IMG_H-2).
REQ-024 While out_valid && !out_ready, out_window, out_x, out_y, out_last hold stable and in_ready=0.
REQ-025 If out_ready=1 and a new window loads in the same cycle, the register is overwritten with no bubble; if out_ready=1 and no window loads, out_valid clears.
REQ-026 Accepted pixels with x<2 or y<2 update buffers and counters only; out_valid is unaffected except per REQ-025.
REQ-027 Pixel arithmetic is pass-through; no value modification, no saturation.

Reset
REQ-028 On clk edge with rst_n=0: out_valid=0, out_last=0, out_window=0, out_x=0, out_y=0, x=0, y=0, shift register=0; line buffer contents are not reset.
REQ-029 in_ready=1 during the first cycle after reset release.
REQ-030 Reset asserted mid-frame abandons the frame; the next accepted pixel is (0,0) whether or not in_sof is set.

Verification
REQ-031 IMG_W=8, IMG_H=6, pixel=(x+y) mod 16, in_valid and out_ready held 1 -> first out_valid one cycle after accepting (2,2), centre (1,1), out_window[1][1]=2, out_window[0][0]=0, out_window[2][2]=4; 24 windows total, out_last on centre (6,4).
REQ-032 Same frame with out_ready=0 for 5 cycles after first window -> window stable, in_ready=0 for 5 cycles, no pixel lost; 24 windows total.
REQ-033 Random in_valid (50%) and out_ready (50%) gaps over 3 back-to-back frames -> every window matches golden model; 72 windows, 3 out_last pulses.
REQ-034 in_sof asserted at pixel (5,3) of frame 1 -> counters resync; next window centre (1,1) after 2 full rows plus 3 pixels; no window from pre-sof data.
REQ-035 rst_n=0 for 1 cycle mid-frame with out_valid=1 -> out_valid=0 next cycle, all outputs 0; subsequent frame produces 24 correct windows.
